// File: rtl/udp_packet_builder.sv
// udp_packet_builder: packs one command plus a stream of 32-bit
// payload words into 256-bit UDP beats for the sum/max parser.
module udp_packet_builder #(
  parameter logic [15:0] SRC_PORT  = 16'd5000,
  parameter logic [15:0] DST_PORT  = 16'd5001,
  parameter int          NUM_BEATS = 63
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [7:0]   cmd_op_i,
  input  logic [31:0]  w_data_i,
  input  logic         w_valid_i,
  output logic         w_ready_o,
  output logic [255:0] a_data_o,
  output logic         a_valid_o,
  input  logic         a_ready_i,
  output logic         pkt_done_o,
  output logic         bad_cmd_o
);

  localparam int WORDS = 5 + 8 * (NUM_BEATS - 3) + 4;
  localparam int LEN_I = 8 + 4 * WORDS;
  localparam logic [15:0] LEN = 16'(LEN_I);
  localparam int BW = $clog2(NUM_BEATS);
  localparam logic [BW-1:0] LAST = BW'(NUM_BEATS - 1);
  localparam logic [7:0] OP_SUM = 8'd1;
  localparam logic [7:0] OP_MAX = 8'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PACK,
    S_SEND
  } state_t;

  state_t          state;
  logic [7:0]      op_q;
  logic [BW-1:0]   beat_q;
  logic [2:0]      lane_q;
  logic [255:0]    beat_buf;

  logic            op_ok;
  logic [2:0]      last_lane;
  logic            is_last;
  logic            next_last;
  logic [255:0]    hdr;

  assign op_ok     = (cmd_op_i == OP_SUM) ||
                     (cmd_op_i == OP_MAX);
  assign last_lane = (beat_q == BW'(1)) ? 3'd4 : 3'd7;
  assign is_last   = (beat_q == LAST);
  assign next_last = ((beat_q + BW'(1)) == LAST);
  assign hdr       = {192'b0, 16'h0000, LEN,
                      DST_PORT, SRC_PORT};
  assign a_data_o  = beat_buf;

  // Packet FSM: header, then per-beat pack/send with held beats.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      op_q        <= 8'd0;
      beat_q      <= '0;
      lane_q      <= 3'd0;
      beat_buf    <= '0;
      cmd_ready_o <= 1'b1;
      w_ready_o   <= 1'b0;
      a_valid_o   <= 1'b0;
      pkt_done_o  <= 1'b0;
      bad_cmd_o   <= 1'b0;
    end else begin
      pkt_done_o <= 1'b0;
      bad_cmd_o  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            if (op_ok) begin
              op_q        <= cmd_op_i;
              beat_q      <= '0;
              lane_q      <= 3'd0;
              beat_buf    <= hdr;
              cmd_ready_o <= 1'b0;
              a_valid_o   <= 1'b1;
              state       <= S_HDR;
            end else begin
              bad_cmd_o <= 1'b1;
            end
          end
        end
        S_HDR: begin
          if (a_ready_i) begin
            beat_q    <= BW'(1);
            lane_q    <= 3'd0;
            beat_buf  <= {88'b0, op_q, 160'b0};
            a_valid_o <= 1'b0;
            w_ready_o <= 1'b1;
            state     <= S_PACK;
          end
        end
        S_PACK: begin
          if (w_valid_i) begin
            beat_buf[{lane_q, 5'b0} +: 32] <= w_data_i;
            if (lane_q == last_lane) begin
              w_ready_o <= 1'b0;
              a_valid_o <= 1'b1;
              state     <= S_SEND;
            end else begin
              lane_q <= lane_q + 3'd1;
            end
          end
        end
        S_SEND: begin
          if (a_ready_i) begin
            a_valid_o <= 1'b0;
            beat_buf  <= '0;
            if (is_last) begin
              pkt_done_o  <= 1'b1;
              cmd_ready_o <= 1'b1;
              beat_q      <= '0;
              lane_q      <= 3'd0;
              state       <= S_IDLE;
            end else begin
              beat_q    <= beat_q + BW'(1);
              lane_q    <= next_last ? 3'd4 : 3'd0;
              w_ready_o <= 1'b1;
              state     <= S_PACK;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
